// File: rtl/if_fetch_stage_if.sv
// Instruction-memory port of the fetch stage: one-cycle request pulse out,
// one-cycle read-data-valid pulse back.
interface if_fetch_stage_if;
  // Handshake: imem_req is a single-cycle pulse that memory always accepts at
  // the clock edge; imem_addr is valid with it. Exactly one imem_rvalid pulse
  // answers each request, at least one cycle later, with imem_rdata valid in
  // the same cycle. There is no ready/backpressure in either direction.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// PC register and instruction-fetch stage: one outstanding fetch at a time,
// result loaded into the IF/ID register, with stall, flush and kill handling.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [31:0]             npc_i,
  input  logic                    pc_write_i,
  input  logic                    ifid_stall_i,
  input  logic                    flush_i,
  if_fetch_stage_if.master        imem,
  output logic [31:0]             pc_o,
  output logic                    ifid_valid_o,
  output logic [31:0]             ifid_pc_o,
  output logic [31:0]             ifid_inst_o,
  output logic                    fetch_busy_o,
  output logic [1:0]              state_o
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] hold_q, hold_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic        req_q, req_d;
  logic        busy_q, busy_d;

  logic        advance;
  logic        take_npc;
  logic        load;
  logic [31:0] load_inst;
  logic [31:0] npc_aligned;
  logic [1:0]  unused_npc_lo;

  assign advance       = pc_write_i & ~ifid_stall_i;
  assign npc_aligned   = {npc_i[31:2], 2'b00};
  assign unused_npc_lo = npc_i[1:0];

  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    hold_d    = hold_q;
    take_npc  = 1'b0;
    load      = 1'b0;
    load_inst = hold_q;

    case (state_q)
      ST_RST: state_d = ST_REQ;

      // The request goes out this cycle regardless; a flush only marks it dead.
      ST_REQ: begin
        state_d = ST_WAIT;
        if (flush_i) begin
          take_npc = 1'b1;
          kill_d   = 1'b1;
        end
      end

      ST_WAIT: begin
        if (!imem.imem_rvalid) begin
          if (flush_i) begin
            take_npc = 1'b1;
            kill_d   = 1'b1;
          end
        end else if (kill_q || flush_i) begin
          kill_d   = 1'b0;
          take_npc = flush_i;
          state_d  = ST_REQ;
        end else if (advance) begin
          load      = 1'b1;
          load_inst = imem.imem_rdata;
          take_npc  = 1'b1;
          state_d   = ST_REQ;
        end else begin
          hold_d  = imem.imem_rdata;
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (flush_i) begin
          hold_d   = NOP_INST;
          take_npc = 1'b1;
          state_d  = ST_REQ;
        end else if (advance) begin
          load      = 1'b1;
          load_inst = hold_q;
          take_npc  = 1'b1;
          state_d   = ST_REQ;
        end
      end

      default: state_d = ST_RST;
    endcase

    pc_d = take_npc ? npc_aligned : pc_q;
  end

  // IF/ID register: flush beats stall beats load; otherwise insert a bubble.
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    if (flush_i) begin
      ifid_valid_d = 1'b0;
      ifid_inst_d  = NOP_INST;
    end else if (ifid_stall_i) begin
      ifid_valid_d = ifid_valid_q;
    end else if (load) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = pc_q;
      ifid_inst_d  = load_inst;
    end else begin
      ifid_valid_d = 1'b0;
      ifid_inst_d  = NOP_INST;
    end
  end

  assign req_d  = (state_d == ST_REQ);
  assign busy_d = (state_d == ST_WAIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_RST;
      pc_q         <= {RESET_PC[31:2], 2'b00};
      kill_q       <= 1'b0;
      hold_q       <= NOP_INST;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0;
      ifid_inst_q  <= NOP_INST;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      hold_q       <= hold_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign pc_o           = pc_q;
  assign ifid_valid_o   = ifid_valid_q;
  assign ifid_pc_o      = ifid_pc_q;
  assign ifid_inst_o    = ifid_inst_q;
  assign fetch_busy_o   = busy_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus a randomized run checked
// against a word-level reference model of the fetch stage.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0] S_RST  = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] npc_i;
  logic        pc_write_i;
  logic        ifid_stall_i;
  logic        flush_i;
  logic [31:0] pc_o;
  logic        ifid_valid_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_inst_o;
  logic        fetch_busy_o;
  logic [1:0]  state_o;

  logic        npc_auto;
  logic [31:0] npc_man;
  assign npc_i = npc_auto ? pc_o + 32'd4 : npc_man;

  if_fetch_stage_if imem ();

  if_fetch_stage dut (
    .clk          (clk),
    .rstn         (rstn),
    .npc_i        (npc_i),
    .pc_write_i   (pc_write_i),
    .ifid_stall_i (ifid_stall_i),
    .flush_i      (flush_i),
    .imem         (imem),
    .pc_o         (pc_o),
    .ifid_valid_o (ifid_valid_o),
    .ifid_pc_o    (ifid_pc_o),
    .ifid_inst_o  (ifid_inst_o),
    .fetch_busy_o (fetch_busy_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // memory model
  logic [31:0] word_q[$];
  logic        mem_busy;
  int          mem_cnt;
  int          mem_lat;
  logic        mem_rand_lat;

  task automatic step();
    @(negedge clk);
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'h0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem.imem_rvalid = 1'b1;
        if (word_q.size() > 0) imem.imem_rdata = word_q.pop_front();
        else imem.imem_rdata = $urandom();
        mem_busy = 1'b0;
      end
    end
    if (imem.imem_req === 1'b1) begin
      mem_busy = 1'b1;
      mem_cnt  = mem_rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    flush_i = 1'b0; ifid_stall_i = 1'b0; pc_write_i = 1'b1;
    npc_auto = 1'b1; npc_man = 32'h0;
    mem_busy = 1'b0; mem_cnt = 0; mem_lat = 1; mem_rand_lat = 1'b0;
    word_q.delete();
    step(); step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    do_reset();
    rstn = 1'b0;
    step(); step();
    n_vec++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc_o, 32'h0); end
    n_vec++; if (ifid_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ifid_valid_o); end
    n_vec++; if (ifid_inst_o !== NOP) begin n_err++; $display("FAIL reset_inst: got %h want %h", ifid_inst_o, NOP); end
    n_vec++; if (ifid_pc_o !== 32'h0) begin n_err++; $display("FAIL reset_ifid_pc: got %h want 0", ifid_pc_o); end
    n_vec++; if (imem.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem.imem_req); end
    n_vec++; if (state_o !== S_RST) begin n_err++; $display("FAIL reset_state: got %0d want %0d", state_o, S_RST); end
    rstn = 1'b1;
    step();
    n_vec++; if (imem.imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", imem.imem_req); end
    n_vec++; if (imem.imem_addr !== 32'h0) begin n_err++; $display("FAIL first_addr: got %h want 0", imem.imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] w [3];
    logic exp_v;
    int idx;
    w[0] = 32'hA; w[1] = 32'hB; w[2] = 32'hC;
    do_reset();
    for (int i = 0; i < 3; i++) word_q.push_back(w[i]);
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_v = (k == 3 || k == 5 || k == 7);
      n_vec++;
      if (ifid_valid_o !== exp_v) begin n_err++; $display("FAIL stream_valid k=%0d: got %b want %b", k, ifid_valid_o, exp_v); end
      if (exp_v) begin
        idx = (k - 3) / 2;
        n_vec++;
        if (ifid_pc_o !== 32'(idx * 4) || ifid_inst_o !== w[idx]) begin
          n_err++; $display("FAIL stream_entry k=%0d: got (%h,%h) want (%h,%h)", k, ifid_pc_o, ifid_inst_o, 32'(idx * 4), w[idx]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic found;
    do_reset();
    word_q.push_back(32'hA); word_q.push_back(32'hB); word_q.push_back(32'hC);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (imem.imem_rvalid === 1'b1 && imem.imem_rdata === 32'hB) found = 1'b1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL stall_wait_b: got timeout want word 0xb"); end
    ifid_stall_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (c == 2) ifid_stall_i = 1'b0;
      n_vec++; if (state_o !== S_HOLD) begin n_err++; $display("FAIL stall_state c=%0d: got %0d want %0d", c, state_o, S_HOLD); end
      n_vec++; if (pc_o !== 32'h4) begin n_err++; $display("FAIL stall_pc c=%0d: got %h want 4", c, pc_o); end
      n_vec++; if (imem.imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req c=%0d: got %b want 0", c, imem.imem_req); end
    end
    step();
    n_vec++;
    if (ifid_valid_o !== 1'b1 || ifid_pc_o !== 32'h4 || ifid_inst_o !== 32'hB) begin
      n_err++; $display("FAIL stall_release: got (%b,%h,%h) want (1,4,b)", ifid_valid_o, ifid_pc_o, ifid_inst_o);
    end
    n_vec++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h8) begin
      n_err++; $display("FAIL stall_next_req: got (%b,%h) want (1,8)", imem.imem_req, imem.imem_addr);
    end
  endtask

  task automatic test_flush_wait();
    logic got;
    do_reset();
    mem_lat = 3;
    word_q.push_back(32'hA); word_q.push_back(32'h55);
    step(); step();
    flush_i = 1'b1; npc_auto = 1'b0; npc_man = 32'h100;
    step();
    flush_i = 1'b0; npc_auto = 1'b1;
    n_vec++; if (pc_o !== 32'h100) begin n_err++; $display("FAIL fw_pc: got %h want 100", pc_o); end
    n_vec++; if (fetch_busy_o !== 1'b1) begin n_err++; $display("FAIL fw_busy: got %b want 1", fetch_busy_o); end
    step();
    n_vec++; if (imem.imem_rvalid !== 1'b1) begin n_err++; $display("FAIL fw_old_rvalid: got %b want 1", imem.imem_rvalid); end
    step();
    n_vec++; if (ifid_valid_o !== 1'b0) begin n_err++; $display("FAIL fw_discard: got valid %b want 0", ifid_valid_o); end
    n_vec++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h100) begin
      n_err++; $display("FAIL fw_next_req: got (%b,%h) want (1,100)", imem.imem_req, imem.imem_addr);
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (ifid_valid_o === 1'b1) got = 1'b1;
    end
    n_vec++;
    if (!got || ifid_pc_o !== 32'h100 || ifid_inst_o !== 32'h55) begin
      n_err++; $display("FAIL fw_refetch: got (%b,%h,%h) want (1,100,55)", got, ifid_pc_o, ifid_inst_o);
    end
  endtask

  task automatic test_flush_rvalid_hold();
    logic got;
    do_reset();
    word_q.push_back(32'h77); word_q.push_back(32'h88); word_q.push_back(32'h99);
    step(); step();
    flush_i = 1'b1; npc_auto = 1'b0; npc_man = 32'h200;
    step();
    flush_i = 1'b0; npc_auto = 1'b1;
    n_vec++;
    if (ifid_valid_o !== 1'b0 || ifid_inst_o !== NOP) begin
      n_err++; $display("FAIL fr_ifid: got (%b,%h) want (0,%h)", ifid_valid_o, ifid_inst_o, NOP);
    end
    n_vec++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h200) begin
      n_err++; $display("FAIL fr_next_req: got (%b,%h) want (1,200)", imem.imem_req, imem.imem_addr);
    end
    step();
    ifid_stall_i = 1'b1;
    step();
    n_vec++; if (state_o !== S_HOLD) begin n_err++; $display("FAIL fh_hold: got %0d want %0d", state_o, S_HOLD); end
    flush_i = 1'b1; npc_auto = 1'b0; npc_man = 32'h300;
    step();
    flush_i = 1'b0; ifid_stall_i = 1'b0; npc_auto = 1'b1;
    n_vec++; if (pc_o !== 32'h300) begin n_err++; $display("FAIL fh_pc: got %h want 300", pc_o); end
    n_vec++;
    if (ifid_valid_o !== 1'b0 || ifid_inst_o !== NOP) begin
      n_err++; $display("FAIL fh_ifid: got (%b,%h) want (0,%h)", ifid_valid_o, ifid_inst_o, NOP);
    end
    n_vec++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h300) begin
      n_err++; $display("FAIL fh_next_req: got (%b,%h) want (1,300)", imem.imem_req, imem.imem_addr);
    end
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      step();
      if (ifid_valid_o === 1'b1) got = 1'b1;
    end
    n_vec++;
    if (!got || ifid_pc_o !== 32'h300 || ifid_inst_o !== 32'h99) begin
      n_err++; $display("FAIL fh_refetch: got (%b,%h,%h) want (1,300,99)", got, ifid_pc_o, ifid_inst_o);
    end
  endtask

  task automatic test_reset_in_wait();
    logic got;
    do_reset();
    mem_lat = 3;
    word_q.push_back(32'hDEAD); word_q.push_back(32'hA0);
    step(); step();
    rstn = 1'b0;
    #1;
    n_vec++;
    if (state_o !== S_RST || imem.imem_req !== 1'b0 || fetch_busy_o !== 1'b0 || ifid_valid_o !== 1'b0 || ifid_inst_o !== NOP || pc_o !== 32'h0) begin
      n_err++; $display("FAIL rw_async: got state %0d req %b busy %b valid %b inst %h pc %h want reset values",
                        state_o, imem.imem_req, fetch_busy_o, ifid_valid_o, ifid_inst_o, pc_o);
    end
    step();
    rstn = 1'b1;
    step();
    n_vec++; if (imem.imem_rvalid !== 1'b1) begin n_err++; $display("FAIL rw_stale_rvalid: got %b want 1", imem.imem_rvalid); end
    n_vec++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin
      n_err++; $display("FAIL rw_restart: got (%b,%h) want (1,0)", imem.imem_req, imem.imem_addr);
    end
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (ifid_valid_o === 1'b1) got = 1'b1;
    end
    n_vec++;
    if (!got || ifid_pc_o !== 32'h0 || ifid_inst_o !== 32'hA0) begin
      n_err++; $display("FAIL rw_refetch: got (%b,%h,%h) want (1,0,a0)", got, ifid_pc_o, ifid_inst_o);
    end
  endtask

  // Word-level model: a returned word reaches IF/ID unless a flush is seen
  // between its request and its delivery; PC moves on delivery or flush.
  task automatic test_random();
    logic [31:0] m_pc, m_oaddr, m_ipc, m_iword, e_pc, e_inst, npc_al;
    logic m_out, m_kill, m_pend, e_valid, adv, deliver;
    int idle;
    do_reset();
    mem_rand_lat = 1'b1;
    npc_auto = 1'b0;
    m_pc = 32'h0; m_out = 1'b0; m_kill = 1'b0; m_pend = 1'b0;
    m_oaddr = 32'h0; m_ipc = 32'h0; m_iword = 32'h0;
    e_valid = 1'b0; e_pc = 32'h0; e_inst = NOP; idle = 0;
    npc_man = 32'h4;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      n_vec++; if (pc_o !== m_pc) begin n_err++; $display("FAIL rnd_pc c=%0d: got %h want %h", cyc, pc_o, m_pc); end
      n_vec++; if (ifid_valid_o !== e_valid) begin n_err++; $display("FAIL rnd_valid c=%0d: got %b want %b", cyc, ifid_valid_o, e_valid); end
      n_vec++; if (ifid_inst_o !== e_inst) begin n_err++; $display("FAIL rnd_inst c=%0d: got %h want %h", cyc, ifid_inst_o, e_inst); end
      if (e_valid) begin
        n_vec++; if (ifid_pc_o !== e_pc) begin n_err++; $display("FAIL rnd_ifid_pc c=%0d: got %h want %h", cyc, ifid_pc_o, e_pc); end
      end
      if (imem.imem_req === 1'b1) begin
        n_vec++; if (m_out || m_pend) begin n_err++; $display("FAIL rnd_overlap c=%0d: got req with one in flight want none", cyc); end
        n_vec++; if (imem.imem_addr !== m_pc) begin n_err++; $display("FAIL rnd_addr c=%0d: got %h want %h", cyc, imem.imem_addr, m_pc); end
        m_out = 1'b1; m_kill = 1'b0; m_oaddr = m_pc; idle = 0;
      end else if (!m_out && !m_pend) begin
        idle++;
        if (idle > 2) begin
          n_vec++; n_err++; idle = 0;
          $display("FAIL rnd_no_req c=%0d: got idle 3 cycles want a request", cyc);
        end
      end
      flush_i      = ($urandom_range(0, 9) == 0);
      ifid_stall_i = ($urandom_range(0, 3) == 0);
      pc_write_i   = ($urandom_range(0, 5) != 0);
      npc_man      = (flush_i || $urandom_range(0, 3) == 0) ? $urandom() : m_pc + 32'd4;
      npc_al       = {npc_man[31:2], 2'b00};
      adv = pc_write_i && !ifid_stall_i;
      if (m_out && flush_i) m_kill = 1'b1;
      if (imem.imem_rvalid === 1'b1) begin
        m_out = 1'b0;
        if (!m_kill) begin m_pend = 1'b1; m_ipc = m_oaddr; m_iword = imem.imem_rdata; end
        m_kill = 1'b0;
      end
      deliver = m_pend && !flush_i && adv;
      if (m_pend && (flush_i || adv)) m_pend = 1'b0;
      if (flush_i || deliver) m_pc = npc_al;
      if (flush_i) begin e_valid = 1'b0; e_inst = NOP; end
      else if (ifid_stall_i) begin e_valid = e_valid; end
      else if (deliver) begin e_valid = 1'b1; e_pc = m_ipc; e_inst = m_iword; end
      else begin e_valid = 1'b0; e_inst = NOP; end
    end
    flush_i = 1'b0; ifid_stall_i = 1'b0; npc_auto = 1'b1;
  endtask

  initial begin
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'h0;
    npc_auto = 1'b1; npc_man = 32'h0;
    flush_i = 1'b0; ifid_stall_i = 1'b0; pc_write_i = 1'b1;
    mem_busy = 1'b0; mem_cnt = 0; mem_lat = 1; mem_rand_lat = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_flush_wait();
    test_flush_rvalid_hold();
    test_reset_in_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
